// File: rtl/regmap_pkg.sv
// Shared types and helpers for the parametrised register map.
// Access-type enum, the per-register access decode, and supported size limits.
package regmap_pkg;

    localparam int unsigned MAX_DATA_W = 32;
    localparam int unsigned MAX_REGS   = 64;

    typedef enum logic [1:0] {
        ACC_RW  = 2'd0,
        ACC_RO  = 2'd1,
        ACC_W1C = 2'd2
    } acc_t;

    // Read-only takes priority when a register appears in both masks.
    function automatic acc_t acc_of(input int unsigned         i,
                                    input logic [MAX_REGS-1:0] ro_mask,
                                    input logic [MAX_REGS-1:0] w1c_mask);
        logic [MAX_REGS-1:0] ro_sh;
        logic [MAX_REGS-1:0] w1c_sh;
        ro_sh  = ro_mask >> i;
        w1c_sh = w1c_mask >> i;
        if (ro_sh[0]) begin
            return ACC_RO;
        end else if (w1c_sh[0]) begin
            return ACC_W1C;
        end
        return ACC_RW;
    endfunction

endpackage

// File: rtl/regmap_if.sv
// Strobe-bus interface between the host decoder (master) and the register map (slave).
interface regmap_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
);
    logic              WRITE;
    logic              READ;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WRITE_DATA;
    logic [DATA_W-1:0] READ_DATA;
    logic              READ_VALID;
    logic              ERR;

    modport master (
        output WRITE, READ, ADDR, WRITE_DATA,
        input  READ_DATA, READ_VALID, ERR
    );

    modport slave (
        input  WRITE, READ, ADDR, WRITE_DATA,
        output READ_DATA, READ_VALID, ERR
    );
endinterface

// File: rtl/regmap_cell.sv
// One register of the map: RW load, W1C clear/set, or stateless HW_IN passthrough for RO.
module regmap_cell
    import regmap_pkg::*;
#(
    parameter int unsigned       DATA_W  = 8,
    parameter acc_t              ACC     = ACC_RW,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] hw_in,
    input  logic [DATA_W-1:0] hw_set,
    output logic [DATA_W-1:0] val_c
);

    if (ACC == ACC_RO) begin : g_ro
        logic unused_ro;
        assign unused_ro = ^{CLK, RST, wr_en, wr_data, hw_set};
        assign val_c     = hw_in;
    end else begin : g_store
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] clr_c;
        logic              unused_store;

        assign clr_c        = wr_en ? wr_data : '0;
        assign unused_store = ^hw_in;

        // Hardware set is applied after the clear so a set wins on a shared bit.
        always_ff @(posedge CLK) begin
            if (RST) begin
                q <= RST_VAL;
            end else if (ACC == ACC_W1C) begin
                q <= (q & ~clr_c) | hw_set;
            end else if (wr_en) begin
                q <= wr_data;
            end
        end

        assign val_c = q;
    end

endmodule

// File: rtl/regmap_param.sv
// Parametrised control/status register map on a WRITE/READ/ADDR strobe bus.
// Registered read data with a valid strobe, error pulse on illegal access, per-register write pulses.
module regmap_param
    import regmap_pkg::*;
#(
    parameter int unsigned                ADDR_W    = 3,
    parameter int unsigned                DATA_W    = 8,
    parameter int unsigned                NUM_REGS  = 4,
    parameter logic [NUM_REGS-1:0]        RO_MASK   = 4'b0100,
    parameter logic [NUM_REGS-1:0]        W1C_MASK  = 4'b1000,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = {8'h00, 8'h00, 8'h00, 8'h5A}
) (
    input  logic                       CLK,
    input  logic                       RST,
    regmap_if.slave                    bus,
    input  logic [NUM_REGS*DATA_W-1:0] HW_IN,
    input  logic [NUM_REGS*DATA_W-1:0] HW_SET,
    output logic [NUM_REGS*DATA_W-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]        WR_PULSE
);

    if (NUM_REGS < 1 || 64'(NUM_REGS) > (64'(1) << ADDR_W)) begin : g_bad_num_regs
        $error("regmap_param: NUM_REGS must be in 1..2**ADDR_W");
    end
    if (NUM_REGS > MAX_REGS) begin : g_bad_max_regs
        $error("regmap_param: NUM_REGS exceeds MAX_REGS");
    end
    if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("regmap_param: DATA_W must be in 1..MAX_DATA_W");
    end

    logic [DATA_W-1:0]   val_c    [NUM_REGS];
    logic [DATA_W-1:0]   rd_chain [NUM_REGS+1];
    logic [NUM_REGS-1:0] sel_c;
    logic [NUM_REGS-1:0] wr_en_c;
    logic                hit_c;
    logic                ro_hit_c;
    logic                err_c;

    assign rd_chain[0] = '0;

    // Per-register decode, storage cell, read-mux term and REG_OUT slice.
    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
        localparam acc_t ACC_I = acc_of(i, 64'(RO_MASK), 64'(W1C_MASK));

        assign sel_c[i]      = (32'(bus.ADDR) == 32'(i));
        assign wr_en_c[i]    = bus.WRITE & sel_c[i] & ~RO_MASK[i];
        assign rd_chain[i+1] = rd_chain[i] | (sel_c[i] ? val_c[i] : '0);

        regmap_cell #(
            .DATA_W  (DATA_W),
            .ACC     (ACC_I),
            .RST_VAL (RESET_VAL[i*DATA_W +: DATA_W])
        ) u_cell (
            .CLK     (CLK),
            .RST     (RST),
            .wr_en   (wr_en_c[i]),
            .wr_data (bus.WRITE_DATA),
            .hw_in   (HW_IN[i*DATA_W +: DATA_W]),
            .hw_set  (HW_SET[i*DATA_W +: DATA_W]),
            .val_c   (val_c[i])
        );

        if (ACC_I == ACC_RO) begin : g_out_ro
            assign REG_OUT[i*DATA_W +: DATA_W] = '0;
        end else begin : g_out_reg
            assign REG_OUT[i*DATA_W +: DATA_W] = val_c[i];
        end
    end

    assign hit_c    = |sel_c;
    assign ro_hit_c = |(sel_c & RO_MASK);
    // Write+read to a bad location still yields one error pulse.
    assign err_c    = (bus.WRITE | bus.READ) & (~hit_c | (bus.WRITE & ro_hit_c));

    // Read data is taken from pre-write register values; unmapped reads return zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.READ_DATA  <= '0;
            bus.READ_VALID <= 1'b0;
            bus.ERR        <= 1'b0;
            WR_PULSE       <= '0;
        end else begin
            bus.READ_VALID <= bus.READ;
            if (bus.READ) begin
                bus.READ_DATA <= rd_chain[NUM_REGS];
            end
            bus.ERR        <= err_c;
            WR_PULSE       <= wr_en_c;
        end
    end

endmodule

// File: doc/regmap_param.md
Name: regmap_param

Overview:
Parametrised register map for control/status access from a simple strobe bus (WRITE/READ/ADDR).
- Supersedes fixed two-register maps.
- Provides configurable width, register count, and per-register access type (RW, RO, W1C).
- Read data is registered with a valid strobe; accesses to unmapped or illegal locations raise an error pulse.
- Sits between the host bus decoder and datapath blocks: drives control registers, samples hardware status.

Parameters:
ADDR_W, 3, address width; NUM_REGS must not exceed 2**ADDR_W.
DATA_W, 8, register and bus data width.
NUM_REGS, 4, number of implemented registers (addresses 0..NUM_REGS-1).
RO_MASK, 4'b0100, bit i=1: register i is read-only; read value comes from HW_IN slice i.
W1C_MASK, 4'b1000, bit i=1: register i is write-1-to-clear, set by HW_SET. If a bit is set in both masks, RO wins.
RESET_VAL, {8'h00,8'h00,8'h00,8'h5A}, packed NUM_REGS*DATA_W reset values; slice i is register i.

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
WRITE  in  1  write strobe, one access per cycle
READ  in  1  read strobe
ADDR  in  ADDR_W  register address
WRITE_DATA  in  DATA_W  write data
READ_DATA  out  DATA_W  registered read data
READ_VALID  out  1  one-cycle pulse, READ_DATA valid
ERR  out  1  one-cycle pulse, illegal access
REG_OUT  out  NUM_REGS*DATA_W  current value of all RW/W1C registers; RO slices drive 0
HW_IN  in  NUM_REGS*DATA_W  status inputs for RO registers
HW_SET  in  NUM_REGS*DATA_W  per-bit set requests for W1C registers
WR_PULSE  out  NUM_REGS  one-cycle pulse, register i accepted a write

Behaviour:
- Reset: RST high at a CLK edge loads every register with RESET_VAL. READ_DATA=0, READ_VALID=0, ERR=0, WR_PULSE=0. HW_SET is ignored while RST is high. Reset overrides any in-flight access; no READ_VALID is produced for a read issued in the reset cycle.
- RW write: WRITE=1, ADDR<NUM_REGS, register is RW. Register <= WRITE_DATA at the next edge. WR_PULSE[ADDR]=1 in the following cycle.
- W1C register, every cycle: reg <= (reg & ~clr) | HW_SET_i, where clr=WRITE_DATA if written this cycle, else 0. Set wins over clear on the same bit in the same cycle. WR_PULSE also fires on a W1C write.
- RO write: no state change, no WR_PULSE, ERR=1 next cycle.
- Unmapped access: ADDR>=NUM_REGS with WRITE or READ gives ERR=1 next cycle. An unmapped read also gives READ_VALID=1 with READ_DATA=0.
- Read latency: exactly 1 cycle.
  - Read at edge N: READ_DATA/READ_VALID are valid after edge N and hold for one cycle.
  - READ_DATA holds its last value when READ_VALID=0.
- Read source:
  - RW/W1C: register value before any write in the same cycle (read-before-write).
  - RO: HW_IN slice sampled at edge N.
- WRITE and READ both high: both performed on the same ADDR, with read-before-write semantics. ERR is a single pulse even if both accesses are illegal.
- Back-to-back accesses every cycle are supported; no stall and no backpressure.
- Width: WRITE_DATA is exactly DATA_W; no partial or byte writes.
- Elaboration: a parameter check fails if NUM_REGS > 2**ADDR_W or NUM_REGS < 1.

Decomposition:
- Package regmap_pkg:
  - enum acc_t {ACC_RW, ACC_RO, ACC_W1C};
  - function acc_of(i, RO_MASK, W1C_MASK) returning acc_t, with RO priority;
  - localparam for the maximum supported DATA_W (32).
- Sub-module regmap_cell, parameters DATA_W, ACC (acc_t), RST_VAL. One storage register: handles RW load and W1C clear/set. For ACC_RO it passes HW_IN through and holds no state.
- Top: generate loop over NUM_REGS instantiating regmap_cell. Also contains the address decode, read mux, READ_VALID/ERR registers, and WR_PULSE registers.

Test Plan:
1. Reset -> REG_OUT slice0=8'h5A, other slices 0. READ ADDR=0 -> next cycle READ_DATA=8'h5A, READ_VALID=1, ERR=0.
2. WRITE ADDR=1 data 8'hC3, then READ ADDR=1 on the next cycle -> WR_PULSE=4'b0010 for one cycle; READ_DATA=8'hC3. WRITE+READ ADDR=1 data 8'h11 in one cycle -> READ_DATA=8'hC3, then REG_OUT slice1=8'h11.
3. HW_IN slice2=8'h77, READ ADDR=2 -> READ_DATA=8'h77. WRITE ADDR=2 data 8'hFF -> ERR=1 for one cycle, WR_PULSE=0, slice2 unchanged.
4. HW_SET slice3=8'h05 for one cycle -> reg3=8'h05. WRITE ADDR=3 data 8'h01 with HW_SET slice3=8'h01 in the same cycle -> reg3 stays 8'h05 (set wins). Next WRITE 8'h01 with no HW_SET -> reg3=8'h04.
5. READ ADDR=6 (unmapped) -> READ_VALID=1, READ_DATA=0, ERR=1. WRITE+READ ADDR=5 -> a single ERR pulse.
6. WRITE ADDR=0 data 8'h33 in the same cycle as RST=1 -> reg0=8'h5A, WR_PULSE=0. A READ issued with RST=1 -> READ_VALID stays 0.
